wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 39 +++
 rtl/wb_fifo.sv | 92 +++++++++
 rtl/wb_queue.sv | 95 +++++++++
 tb/tb_wb_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants, entry type and ring-index helpers for the write-back queue.
package wb_pkg;

    localparam int WB_DW    = 8;
    localparam int WB_AW    = 2;
    localparam int WB_DEPTH = 2;

    localparam int WB_MAXD  = 4;   // storage is always sized for the largest legal DEPTH
    localparam int WB_PW    = 2;
    localparam int WB_CW    = 3;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    function automatic logic [WB_PW-1:0] wb_ptr_inc(input logic [WB_PW-1:0] ptr,
                                                    input int depth);
        logic [WB_PW-1:0] nxt;
        if (int'(ptr) >= depth - 1) begin
            nxt = '0;
        end else begin
            nxt = ptr + 2'd1;
        end
        return nxt;
    endfunction

    function automatic logic [WB_PW-1:0] wb_slot(input logic [WB_PW-1:0] base,
                                                 input int offset,
                                                 input int depth);
        int s;
        s = int'(base) + offset;
        if (s >= depth) begin
            s = s - depth;
        end
        return WB_PW'(s);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for the write-back queue: pointers, occupancy and raw
// slot contents, exposed so the parent can search every buffered entry.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [AW-1:0]    push_addr_i,
    input  logic [DW-1:0]    push_data_i,
    output logic [AW-1:0]    head_addr_o,
    output logic [DW-1:0]    head_data_o,
    output logic [WB_CW-1:0] count_o,
    output logic [WB_PW-1:0] rd_ptr_o,
    output logic [AW-1:0]    mem_addr_o [WB_MAXD],
    output logic [DW-1:0]    mem_data_o [WB_MAXD]
);

    localparam logic [WB_CW-1:0] DEPTH_C = WB_CW'(DEPTH);

    logic [WB_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [WB_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [WB_CW-1:0] count_q, count_d;
    logic [AW-1:0]    addr_q [WB_MAXD];
    logic [DW-1:0]    data_q [WB_MAXD];
    logic             push_ok, pop_ok;

    // Guard locally so a misbehaving parent can never overrun or underrun.
    assign push_ok = push_i && !flush_i && (count_q < DEPTH_C);
    assign pop_ok  = pop_i  && !flush_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wb_ptr_inc(wr_ptr_q, DEPTH);
            end
            if (pop_ok) begin
                rd_ptr_d = wb_ptr_inc(rd_ptr_q, DEPTH);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WB_MAXD; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU/memory results ahead of the register-file write
// port and provides operand bypass plus a per-register pending scoreboard.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic [DW-1:0]     in_data,
    input  logic              wr_stall,
    input  logic              flush,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    input  logic [AW-1:0]     rd_addrA,
    input  logic [AW-1:0]     rd_addrB,
    output logic              bypA_hit,
    output logic              bypB_hit,
    output logic [DW-1:0]     bypA_data,
    output logic [DW-1:0]     bypB_data,
    output logic [2**AW-1:0]  pending,
    output logic [2:0]        count
);

    localparam logic [WB_CW-1:0] DEPTH_C = WB_CW'(DEPTH);

    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic [WB_CW-1:0] fifo_count;
    logic [WB_PW-1:0] rd_ptr;
    logic [AW-1:0]    mem_addr [WB_MAXD];
    logic [DW-1:0]    mem_data [WB_MAXD];
    logic             push, not_empty;
    logic [WB_PW-1:0] slot;

    assign not_empty = (fifo_count != '0);
    // in_ready depends on stored occupancy only, so a full queue never passes through.
    assign in_ready  = (fifo_count < DEPTH_C);
    assign push      = in_valid && in_ready && !flush;
    assign wr_en     = not_empty && !wr_stall && !flush;
    assign wr_addr   = not_empty ? head_addr : '0;
    assign wr_data   = not_empty ? head_data : '0;
    assign count     = fifo_count;

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pop_i       (wr_en),
        .flush_i     (flush),
        .push_addr_i (in_addr),
        .push_data_i (in_data),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (fifo_count),
        .rd_ptr_o    (rd_ptr),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data)
    );

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        bypA_hit  = 1'b0;
        bypB_hit  = 1'b0;
        bypA_data = '0;
        bypB_data = '0;
        pending   = '0;
        slot      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = wb_slot(rd_ptr, k, DEPTH);
            if (k < int'(fifo_count)) begin
                if (mem_addr[slot] == rd_addrA) begin
                    bypA_hit  = 1'b1;
                    bypA_data = mem_data[slot];
                end
                if (mem_addr[slot] == rd_addrB) begin
                    bypB_hit  = 1'b1;
                    bypB_data = mem_data[slot];
                end
                pending[mem_addr[slot]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed scenarios followed by random traffic,
// all checked against a queue model of the buffered entries.
module tb_wb_queue;
    import wb_pkg::*;

    localparam int TB_DEPTH = 2;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_addr;
    logic [7:0] in_data;
    logic       wr_stall;
    logic       flush;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addrA, rd_addrB;
    logic       bypA_hit, bypB_hit;
    logic [7:0] bypA_data, bypB_data;
    logic [3:0] pending;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int occ_q    = 0;
    wb_entry_t sb_q[$];

    wb_queue #(.DEPTH(TB_DEPTH), .DW(8), .AW(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .wr_stall  (wr_stall),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addrA  (rd_addrA),
        .rd_addrB  (rd_addrB),
        .bypA_hit  (bypA_hit),
        .bypB_hit  (bypB_hit),
        .bypA_data (bypA_data),
        .bypB_data (bypB_data),
        .pending   (pending),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model state at this cycle is whatever the scoreboard holds.
    always @(negedge clk) begin : monitor
        int sz;
        logic eh_a, eh_b, ew;
        logic [7:0] ed_a, ed_b;
        logic [3:0] ep;
        sz    = sb_q.size();
        occ_q = sz;
        eh_a = 1'b0; eh_b = 1'b0; ed_a = '0; ed_b = '0; ep = '0;
        foreach (sb_q[i]) begin
            if (sb_q[i].addr == rd_addrA) begin eh_a = 1'b1; ed_a = sb_q[i].data; end
            if (sb_q[i].addr == rd_addrB) begin eh_b = 1'b1; ed_b = sb_q[i].data; end
            ep[sb_q[i].addr] = 1'b1;
        end
        chk("count", 32'(count), 32'(sz));
        chk("in_ready", 32'(in_ready), 32'(sz < TB_DEPTH));
        chk("pending", 32'(pending), 32'(ep));
        chk("bypA_hit", 32'(bypA_hit), 32'(eh_a));
        chk("bypA_data", 32'(bypA_data), 32'(ed_a));
        chk("bypB_hit", 32'(bypB_hit), 32'(eh_b));
        chk("bypB_data", 32'(bypB_data), 32'(ed_b));
        ew = (sz != 0) && !wr_stall && !flush;
        chk("wr_en", 32'(wr_en), 32'(ew));
        if (ew) begin
            chk("wr_addr", 32'(wr_addr), 32'(sb_q[0].addr));
            chk("wr_data", 32'(wr_data), 32'(sb_q[0].data));
            void'(sb_q.pop_front());
        end else if (sz == 0) begin
            chk("wr_addr_empty", 32'(wr_addr), 32'd0);
            chk("wr_data_empty", 32'(wr_data), 32'd0);
        end
        if (flush) sb_q.delete();
    end

    // Drive one cycle; the model takes the offer if it had room at cycle start.
    task automatic step(input logic v, input logic [1:0] a, input logic [7:0] d,
                        input logic st, input logic fl,
                        input logic [1:0] ra, input logic [1:0] rb);
        in_valid = v; in_addr = a; in_data = d;
        wr_stall = st; flush = fl; rd_addrA = ra; rd_addrB = rb;
        @(posedge clk);
        if (reset_n && v && !fl && occ_q < TB_DEPTH)
            sb_q.push_back(wb_entry_t'{addr: a, data: d});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wr_stall = 1'b0; flush = 1'b0; rd_addrA = '0; rd_addrB = '0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Single push then immediate write-back
        step(1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 2'd0, 2'd1);
        chk("single_wr_en", 32'(wr_en), 32'd1);
        chk("single_wr_addr", 32'(wr_addr), 32'd2);
        chk("single_wr_data", 32'(wr_data), 32'h5A);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1);
        chk("single_wr_en_after", 32'(wr_en), 32'd0);
        chk("single_count_after", 32'(count), 32'd0);

        // Stalled pair to the same register, youngest bypass
        step(1'b1, 2'd1, 8'h11, 1'b1, 1'b0, 2'd1, 2'd0);
        step(1'b1, 2'd1, 8'h22, 1'b1, 1'b0, 2'd1, 2'd0);
        chk("stall_count", 32'(count), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_pending", 32'(pending), 32'b0010);
        chk("stall_bypA_hit", 32'(bypA_hit), 32'd1);
        chk("stall_bypA_data", 32'(bypA_data), 32'h22);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd1, 2'd0);
        chk("stall_second_wr_en", 32'(wr_en), 32'd1);
        chk("stall_second_wr_data", 32'(wr_data), 32'h22);
        idle(2);

        // Full queue, stall released while offer held
        step(1'b1, 2'd1, 8'hA1, 1'b1, 1'b0, 2'd1, 2'd3);
        step(1'b1, 2'd3, 8'hA2, 1'b1, 1'b0, 2'd1, 2'd3);
        step(1'b1, 2'd2, 8'hB3, 1'b0, 1'b0, 2'd2, 2'd3);
        step(1'b1, 2'd2, 8'hB3, 1'b0, 1'b0, 2'd2, 2'd3);
        chk("full_count", 32'(count), 32'd1);
        chk("full_wr_data", 32'(wr_data), 32'hB3);
        idle(2);

        // Flush with a simultaneous offer
        step(1'b1, 2'd0, 8'hC1, 1'b1, 1'b0, 2'd0, 2'd2);
        step(1'b1, 2'd2, 8'hC2, 1'b1, 1'b0, 2'd0, 2'd2);
        step(1'b1, 2'd3, 8'h77, 1'b0, 1'b1, 2'd3, 2'd2);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_pending", 32'(pending), 32'd0);
        idle(2);

        // Asynchronous reset in the middle of a drain
        step(1'b1, 2'd1, 8'hD1, 1'b1, 1'b0, 2'd1, 2'd2);
        step(1'b1, 2'd2, 8'hD2, 1'b1, 1'b0, 2'd1, 2'd2);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd1, 2'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_bypB_hit", 32'(bypB_hit), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        idle(3);

        // Bypass hit and miss on the two read ports
        step(1'b1, 2'd3, 8'hFF, 1'b1, 1'b0, 2'd3, 2'd2);
        step(1'b1, 2'd0, 8'h01, 1'b1, 1'b0, 2'd3, 2'd2);
        chk("byp_A_hit", 32'(bypA_hit), 32'd1);
        chk("byp_A_data", 32'(bypA_data), 32'hFF);
        chk("byp_B_hit", 32'(bypB_hit), 32'd0);
        chk("byp_B_data", 32'(bypB_data), 32'h00);
        idle(3);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 6),
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 99) < 3),
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
